// File: rtl/axil_slave_mem_if.sv
// axil_slave_mem_if: AXI4-Lite bus bundle between a master and axil_slave_mem
interface axil_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_slave_mem.sv
// axil_slave_mem: AXI4-Lite slave memory with byte strobes, wait states and SLVERR decode
module axil_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    WR_WAIT    = 0,
    parameter int                    RD_WAIT    = 0
) (
    input logic             clk,
    input logic             reset,
    axil_slave_mem_if.slave bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    w_state_t              w_state;
    r_state_t              r_state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic [3:0]            w_cnt, r_cnt;
    logic                  aw_hs, w_hs, ar_hs, w_fire, w_commit, r_sample;
    logic [ADDR_WIDTH-1:0] wa, ra;
    logic [DATA_WIDTH-1:0] wd;
    logic [NB-1:0]         ws;
    function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return a >= BASE_ADDR && off[ADDR_WIDTH-1:LSB+IW] == '0;
    endfunction
    function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[LSB +: IW];
    endfunction
    assign bus.awready = !reset && w_state == W_IDLE && !aw_held;
    assign bus.wready  = !reset && w_state == W_IDLE && !w_held;
    assign bus.arready = !reset && r_state == R_IDLE;
    assign aw_hs    = bus.awvalid && bus.awready;
    assign w_hs     = bus.wvalid && bus.wready;
    assign ar_hs    = bus.arvalid && bus.arready;
    assign wa       = aw_held ? aw_addr : bus.awaddr;
    assign wd       = w_held ? w_data : bus.wdata;
    assign ws       = w_held ? w_strb : bus.wstrb;
    assign ra       = r_state == R_IDLE ? bus.araddr : ar_addr;
    assign w_fire   = w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
    assign w_commit = !reset && ((w_fire && WR_WAIT == 0) || (w_state == W_WAIT && w_cnt == 4'd1));
    assign r_sample = !reset && ((ar_hs && RD_WAIT == 0) || (r_state == R_WAIT && r_cnt == 4'd1));
    // Byte-lane write of the committed transaction; out-of-range writes leave memory untouched
    always_ff @(posedge clk) begin
        if (w_commit && hit(wa))
            for (int i = 0; i < NB; i++)
                if (ws[i]) mem[idx(wa)][8*i +: 8] <= wd[8*i +: 8];
    end
    // Write channel: latch AW and W independently, count wait states, hold B until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state    <= W_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_addr    <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            w_cnt      <= '0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        aw_addr <= bus.awaddr;
                    end
                    if (w_hs) begin
                        w_held <= 1'b1;
                        w_data <= bus.wdata;
                        w_strb <= bus.wstrb;
                    end
                    if (w_fire) begin
                        w_state <= WR_WAIT == 0 ? W_RESP : W_WAIT;
                        w_cnt   <= 4'(WR_WAIT);
                    end
                end
                W_WAIT: w_cnt <= w_cnt - 4'd1;
                W_RESP: if (bus.bready) begin
                    w_state    <= W_IDLE;
                    bus.bvalid <= 1'b0;
                    aw_held    <= 1'b0;
                    w_held     <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
            if (w_commit) begin
                w_state    <= W_RESP;
                bus.bvalid <= 1'b1;
                bus.bresp  <= hit(wa) ? 2'b00 : 2'b10;
            end
        end
    end
    // Read channel: latch AR, count wait states, sample memory (read-before-write), hold R until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            ar_addr    <= '0;
            r_cnt      <= '0;
            bus.rvalid <= 1'b0;
            bus.rresp  <= 2'b00;
            bus.rdata  <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    ar_addr <= bus.araddr;
                    r_cnt   <= 4'(RD_WAIT);
                    r_state <= RD_WAIT == 0 ? R_DATA : R_WAIT;
                end
                R_WAIT: r_cnt <= r_cnt - 4'd1;
                R_DATA: if (bus.rready) begin
                    r_state    <= R_IDLE;
                    bus.rvalid <= 1'b0;
                end
                default: r_state <= R_IDLE;
            endcase
            if (r_sample) begin
                r_state    <= R_DATA;
                bus.rvalid <= 1'b1;
                bus.rdata  <= hit(ra) ? mem[idx(ra)] : '0;
                bus.rresp  <= hit(ra) ? 2'b00 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_axil_slave_mem.sv
// tb_axil_slave_mem: directed and randomized checks of two slave instances against a word-array model
module tb_axil_slave_mem;
    logic clk, reset, sel;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [2][256];
    bit          known [2][256];
    axil_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
    axil_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
    axil_slave_mem #(.BASE_ADDR(32'h0), .WR_WAIT(0), .RD_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    axil_slave_mem #(.BASE_ADDR(32'h1000), .WR_WAIT(3), .RD_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(b1));
    assign b0.awaddr = awaddr;
    assign b1.awaddr = awaddr;
    assign b0.wdata = wdata;
    assign b1.wdata = wdata;
    assign b0.wstrb = wstrb;
    assign b1.wstrb = wstrb;
    assign b0.araddr = araddr;
    assign b1.araddr = araddr;
    assign b0.awvalid = awvalid && !sel;
    assign b1.awvalid = awvalid && sel;
    assign b0.wvalid = wvalid && !sel;
    assign b1.wvalid = wvalid && sel;
    assign b0.bready = bready && !sel;
    assign b1.bready = bready && sel;
    assign b0.arvalid = arvalid && !sel;
    assign b1.arvalid = arvalid && sel;
    assign b0.rready = rready && !sel;
    assign b1.rready = rready && sel;
    assign awready = sel ? b1.awready : b0.awready;
    assign wready  = sel ? b1.wready : b0.wready;
    assign bvalid  = sel ? b1.bvalid : b0.bvalid;
    assign bresp   = sel ? b1.bresp : b0.bresp;
    assign arready = sel ? b1.arready : b0.arready;
    assign rvalid  = sel ? b1.rvalid : b0.rvalid;
    assign rresp   = sel ? b1.rresp : b0.rresp;
    assign rdata   = sel ? b1.rdata : b0.rdata;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    function automatic int exp_idx(input int s, input logic [31:0] a);
        logic [31:0] base;
        base = s != 0 ? 32'h1000 : 32'h0;
        if (a < base || (a - base) / 32'd4 >= 32'd256) return -1;
        return int'((a - base) / 32'd4);
    endfunction
    function automatic logic [1:0] model_write(input int s, input logic [31:0] a, d, input logic [3:0] st);
        int i;
        i = exp_idx(s, a);
        if (i < 0) return 2'b10;
        for (int b = 0; b < 4; b++) if (st[b]) ref_mem[s][i][8*b +: 8] = d[8*b +: 8];
        if (st == 4'hF) known[s][i] = 1'b1;
        return 2'b00;
    endfunction
    function automatic logic [31:0] rand_addr(input int s);
        logic [31:0] base;
        int r;
        base = s != 0 ? 32'h1000 : 32'h0;
        r = $urandom_range(0, 9);
        if (r == 0) return base + 32'h400 + 32'($urandom_range(0, 1023));
        if (r == 1 && s != 0) return 32'($urandom_range(0, 32'hFFF));
        return base + 32'($urandom_range(0, 1023));
    endfunction
    task automatic do_write(input logic [31:0] a, d, input logic [3:0] st, input logic [1:0] exp_r, input int exp_lat, input int hold);
        int n, lat;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = st; awvalid = 1'b1; wvalid = 1'b1; bready = hold == 0;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        check("aw_w_ready", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 40) begin
            check("aw_w_busy", {awready, wready}, 2'b00);
            @(negedge clk);
            lat++;
        end
        check("b_latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            check("b_hold", {bvalid, bresp, awready, wready}, {1'b1, exp_r, 2'b00});
            @(negedge clk);
        end
        check("bresp", bresp, exp_r);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_done", {bvalid, awready, wready}, 3'b011);
    endtask
    task automatic do_read(input logic [31:0] a, exp_d, input logic [1:0] exp_r, input int exp_lat, input int hold);
        int n, lat;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = hold == 0;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("ar_ready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 40) begin
            check("ar_busy", arready, 0);
            @(negedge clk);
            lat++;
        end
        check("r_latency", lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            check("r_hold", {rvalid, rresp, rdata, arready}, {1'b1, exp_r, exp_d, 1'b0});
            @(negedge clk);
        end
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("r_done", {rvalid, arready}, 2'b01);
    endtask
    task automatic wr(input logic [31:0] a, d, input logic [3:0] st, input int hold);
        logic [1:0] r;
        r = model_write(int'(sel), a, d, st);
        do_write(a, d, st, r, sel ? 4 : 1, hold);
    endtask
    task automatic rd(input logic [31:0] a, input int hold);
        int i;
        i = exp_idx(int'(sel), a);
        do_read(a, i < 0 ? 32'h0 : ref_mem[sel][i], i < 0 ? 2'b10 : 2'b00, sel ? 4 : 1, hold);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat, i;
        logic [31:0] a;
        sel = 1'b0; reset = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_ready", {awready, wready, arready}, 3'b000);
            check("rst_valid", {bvalid, rvalid}, 2'b00);
            check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("post_rst_ready", {awready, wready, arready}, 3'b111);
        end
        sel = 1'b0;
        for (int k = 0; k < 256; k++) wr(32'(k * 4), $urandom, 4'hF, 0);
        wr(32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_read(32'h10, 32'hDEADBEEF, 2'b00, 1, 0);
        @(negedge clk);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
        check("wfirst_wready", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
        check("wfirst_held", {wready, awready, bvalid}, 3'b010);
        @(negedge clk);
        check("wfirst_nob", bvalid, 0);
        @(negedge clk);
        awaddr = 32'h10; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("wfirst_b", {bvalid, bresp}, 3'b100);
        @(negedge clk);
        bready = 1'b0;
        void'(model_write(0, 32'h10, 32'h11223344, 4'b0101));
        do_read(32'h10, 32'hDE22BE44, 2'b00, 1, 0);
        wr(32'h400, 32'hAAAAAAAA, 4'hF, 1);
        rd(32'h400, 0);
        rd(32'h0, 0);
        rd(32'h7FF, 1);
        for (int k = 0; k < 60; k++) begin
            wr(rand_addr(0), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            rd(rand_addr(0), $urandom_range(0, 2));
        end
        sel = 1'b1;
        wr(32'h1040, 32'hCAFEF00D, 4'hF, 5);
        rd(32'h1043, 5);
        wr(32'h0FFC, 32'h12345678, 4'hF, 0);
        rd(32'h0FFC, 0);
        rd(32'h1400, 0);
        wr(32'h1020, 32'h0, 4'hF, 0);
        @(negedge clk);
        awaddr = 32'h1020; wdata = 32'hAAAA5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h1020; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        check("col_ready", {awready, wready, arready}, 3'b111);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        lat = 1;
        while (!(bvalid && rvalid) && lat < 20) begin @(negedge clk); lat++; end
        check("col_latency", lat, 4);
        check("col_old_data", {rdata, rresp, bresp}, 36'h0);
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        void'(model_write(1, 32'h1020, 32'hAAAA5555, 4'hF));
        rd(32'h1020, 0);
        for (int k = 0; k < 40; k++) begin
            a = rand_addr(1);
            wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            i = $urandom_range(0, 255);
            rd(known[1][i] ? 32'h1000 + 32'(i * 4) + 32'($urandom_range(0, 3)) : rand_addr(1), $urandom_range(0, 2));
        end
        @(negedge clk);
        awaddr = 32'h1080; wdata = 32'h0BADCAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
        check("rstb_latency", lat, 4);
        reset = 1'b1;
        @(negedge clk);
        check("rstb_drop", {bvalid, awready, wready, arready}, 4'b0000);
        reset = 1'b0;
        @(negedge clk);
        check("rstb_after", {bvalid, awready, wready, arready}, 4'b0111);
        void'(model_write(1, 32'h1080, 32'h0BADCAFE, 4'hF));
        rd(32'h1080, 0);
        sel = 1'b0;
        rd(32'h10, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
